bus_arbiter: RTL
================

# bus_arbiter

Two-port memory bus arbiter and cycle sequencer that shares the single system memory bus between the CPU6 core and a DMA requester (disk/serial block controller). It arbitrates each transaction round-robin, with a bounded DMA burst lock. It drives the memory address, data and write strobe, inserts a fixed number of wait states, returns read data, and signals completion to the winning requester with a one-cycle acknowledge.

## Interface

- WAIT_STATES, 1, extra memory cycles per access (0..15); the ACCESS phase lasts WAIT_STATES+1 cycles.
- DMA_BURST_MAX, 4, maximum consecutive DMA grants under dma_lock while cpu_req is pending (1..255).

- clock  in  1  system clock; all logic rising-edge.
- reset  in  1  synchronous, active-high.
- cpu_req  in  1  CPU transaction request; level, held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  16  CPU address.
- cpu_wdata  in  8  CPU write data.
- cpu_rdata  out  8  registered read data, valid while cpu_ack = 1.
- cpu_ack  out  1  one-cycle completion pulse.
- dma_req, dma_we, dma_addr[16], dma_wdata[8]  in  DMA equivalents of the CPU request inputs.
- dma_lock  in  1  DMA requests burst priority.
- dma_rdata  out  8, dma_ack  out  1  DMA equivalents of the CPU response outputs.
- mem_addr  out  16  registered memory address.
- mem_wdata  out  8  registered write data.
- mem_en  out  1  bus cycle active.
- mem_we  out  1  write strobe.
- mem_rdata  in  8  memory read data; valid in the last ACCESS cycle.
- cpu_grant, dma_grant  out  1 each  current owner; mutually exclusive.
- busy  out  1  state != IDLE.

## Operation

- The state machine has three states: IDLE, ACCESS and DONE. Reset state is IDLE.
- **IDLE:** requests are sampled at the clock edge.
  - If neither request is asserted, the block stays in IDLE.
  - If exactly one request is asserted, that requester wins.
  - On a tie, the requester not granted last wins, except in the burst case below.
  - last_owner resets to DMA, so the CPU wins the first tie.
- **Burst rule:**
  - When last_owner = DMA, dma_lock = 1 and burst_cnt < DMA_BURST_MAX, DMA wins ties.
  - burst_cnt increments on each DMA grant. It saturates at DMA_BURST_MAX.
  - burst_cnt clears on any CPU grant, or on a DMA grant with dma_lock = 0 (which then loads 1).
- **Grant edge:** on the IDLE→ACCESS edge the block performs all of the following:
  - registers the winner's addr, wdata and we into mem_addr, mem_wdata and an internal we_q;
  - sets the winner's grant;
  - loads wait_cnt = WAIT_STATES;
  - updates last_owner.
  - After the grant edge, the requester's addr, wdata and we may change.
- **ACCESS:** mem_en = 1 for all WAIT_STATES+1 cycles.
  - wait_cnt decrements each cycle.
  - When wait_cnt = 0, this is the final cycle:
    - mem_we = we_q, as a single-cycle write strobe;
    - for a read, mem_rdata is captured into the owner's rdata register at the closing edge;
    - the state moves to DONE.
- **DONE (one cycle):**
  - The owner's ack = 1 and its rdata holds the captured value. The other port's rdata is unchanged.
  - mem_en = 0 and mem_we = 0; the grant remains asserted.
  - The next state is IDLE and the grant clears.
- **Requester contract:** a requester must drop its req in the cycle following ack. A req still high when sampled in IDLE starts a new transaction.
- **Simultaneous events:** requests that arrive while the block is in ACCESS or DONE are ignored until IDLE. dma_lock is examined only in IDLE.
- **Reset in ACCESS or DONE:** the transaction is aborted and no ack is issued. Every output returns to its reset value on the next edge.
- **Widths:**
  - wait_cnt is 4 bits; burst_cnt is 8 bits.
  - Parameter values outside their stated ranges are a configuration error and are not supported.

## Timing

- Reset values: cpu_rdata = 0, dma_rdata = 0, cpu_ack = 0, dma_ack = 0, mem_addr = 0, mem_wdata = 0, mem_en = 0, mem_we = 0, cpu_grant = 0, dma_grant = 0, busy = 0.
- All outputs are registered; there is no combinational path from any input to any output.
- Latency from a req sampled in IDLE at edge k to the ack cycle is WAIT_STATES+2 cycles: the ack is high during cycle k+WAIT_STATES+2.
- Minimum repeat period for one requester is WAIT_STATES+3 cycles, because IDLE lasts at least one cycle.
- With WAIT_STATES = 0: ACCESS lasts one cycle, mem_we pulses in that cycle, and ack follows in the next cycle.
- mem_addr and mem_wdata are stable from the grant edge through the end of DONE.

## Test plan

- **CPU read, WAIT_STATES = 1:** cpu_req, cpu_addr = 0x1234, mem_rdata = 0xA5 → mem_en high for 2 cycles with mem_addr = 0x1234 and mem_we = 0; cpu_ack one cycle with cpu_rdata = 0xA5, 3 cycles after sampling; dma_ack stays 0.
- **DMA write:** dma_addr = 0x8000, dma_wdata = 0x3C, dma_we = 1 → mem_we high for exactly 1 cycle (the final ACCESS cycle) with mem_wdata = 0x3C; dma_ack pulses once.
- **Tie, round-robin:** cpu_req and dma_req both held high, dma_lock = 0, each side dropping req the cycle after its ack and re-raising it → grants alternate CPU, DMA, CPU, DMA; never two grants asserted at once.
- **Burst lock, DMA_BURST_MAX = 4:** cpu_req and dma_req held, dma_lock = 1, DMA granted first → grants DMA ×4 then CPU, then DMA; burst_cnt clears on the CPU grant.
- **Reset mid-ACCESS, WAIT_STATES = 3:** reset asserted in the second ACCESS cycle → next edge: every output at its reset value, busy = 0, no ack; the following cpu_req completes normally.
- **WAIT_STATES = 0 back-to-back:** a DMA read followed immediately by a CPU write → each completes in 2 cycles after its sample, separated by one IDLE cycle; cpu_rdata is unchanged by the DMA read.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-port memory bus arbiter: round-robin CPU/DMA arbitration with a bounded
// DMA burst lock, fixed wait-state sequencing and one-cycle completion acks.
module bus_arbiter #(
  parameter int unsigned WAIT_STATES   = 1,
  parameter int unsigned DMA_BURST_MAX = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  input  logic        dma_lock,
  output logic [7:0]  dma_rdata,
  output logic        dma_ack,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_en,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic        cpu_grant,
  output logic        dma_grant,
  output logic        busy
);

  // state  | meaning
  // IDLE   | bus free, requests sampled and arbitrated each edge
  // ACCESS | memory cycle in progress, WAIT_STATES+1 cycles
  // DONE   | ack to the owner, grant still held, back to IDLE next
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
  localparam logic [7:0] BURST_MAX = 8'(DMA_BURST_MAX);

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [7:0]  burst_cnt;
  logic        last_dma;
  logic        owner_dma;
  logic        we_q;

  logic        burst_hold;
  logic        pick_dma;
  logic        sel_we;
  logic [15:0] sel_addr;
  logic [7:0]  sel_wdata;

  // On a tie the DMA side only keeps the bus if it also won last time and
  // its lock is still within the burst allowance.
  always_comb begin
    burst_hold = last_dma && dma_lock && (burst_cnt < BURST_MAX);
    pick_dma   = dma_req && (!cpu_req || !last_dma || burst_hold);
    sel_we     = pick_dma ? dma_we    : cpu_we;
    sel_addr   = pick_dma ? dma_addr  : cpu_addr;
    sel_wdata  = pick_dma ? dma_wdata : cpu_wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      burst_cnt <= '0;
      last_dma  <= 1'b1;
      owner_dma <= 1'b0;
      we_q      <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      cpu_grant <= 1'b0;
      dma_grant <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req || dma_req) begin
            state     <= ACCESS;
            owner_dma <= pick_dma;
            last_dma  <= pick_dma;
            cpu_grant <= !pick_dma;
            dma_grant <= pick_dma;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            we_q      <= sel_we;
            wait_cnt  <= WAIT_INIT;
            mem_en    <= 1'b1;
            mem_we    <= sel_we && (WAIT_INIT == 4'd0);
            busy      <= 1'b1;
            if (!pick_dma)
              burst_cnt <= '0;
            else if (!dma_lock)
              burst_cnt <= 8'd1;
            else if (burst_cnt < BURST_MAX)
              burst_cnt <= burst_cnt + 8'd1;
          end
        end
        ACCESS: begin
          if (wait_cnt == 4'd0) begin
            state  <= DONE;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (owner_dma) dma_ack <= 1'b1;
            else           cpu_ack <= 1'b1;
            if (!we_q) begin
              if (owner_dma) dma_rdata <= mem_rdata;
              else           cpu_rdata <= mem_rdata;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
            // strobe is raised one edge early so it lands on the final cycle
            mem_we   <= we_q && (wait_cnt == 4'd1);
          end
        end
        DONE: begin
          state     <= IDLE;
          cpu_grant <= 1'b0;
          dma_grant <= 1'b0;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
